// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: result source
// selector and RV32 load funct3 encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_IMM  = 2'd3
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: MEM/WB pipeline entry, long-latency result channel and the
// register-file write port. dbg_count exposes the LU FIFO occupancy.
//
// Handshake: an LU result transfers on a cycle where lu_valid_i and lu_ready_o
// are both high; the producer holds lu_valid_i/lu_rd_i/lu_data_i until then.
// The pipeline entry has no ready; stall_o=1 means re-present it next cycle.
interface wb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              valid_i;
  logic              reg_write_i;
  logic [REG_AW-1:0] rd_i;
  logic [1:0]        result_src_i;
  logic [XLEN-1:0]   alu_result_i;
  logic [XLEN-1:0]   load_data_i;
  logic [2:0]        load_funct3_i;
  logic [1:0]        addr_lo_i;
  logic [XLEN-1:0]   pc_plus4_i;
  logic [XLEN-1:0]   imm_ext_i;
  logic              lu_valid_i;
  logic [REG_AW-1:0] lu_rd_i;
  logic [XLEN-1:0]   lu_data_i;
  logic              lu_ready_o;
  logic              stall_o;
  logic              reg_write_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   result_o;
  logic [7:0]        dbg_count;

  modport master (
    output valid_i, reg_write_i, rd_i, result_src_i, alu_result_i,
           load_data_i, load_funct3_i, addr_lo_i, pc_plus4_i, imm_ext_i,
           lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o, stall_o, reg_write_o, rd_o, result_o, dbg_count
  );

  modport slave (
    input  valid_i, reg_write_i, rd_i, result_src_i, alu_result_i,
           load_data_i, load_funct3_i, addr_lo_i, pc_plus4_i, imm_ext_i,
           lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o, stall_o, reg_write_o, rd_o, result_o, dbg_count
  );
endinterface

// File: rtl/wb_arbiter_load_extend.sv
// Combinational load extraction: picks the byte/half addressed by addr_lo
// and sign- or zero-extends it; LW and unknown funct3 pass the word through.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: selects the pipeline result and shares the register-file
// write port with a buffered long-latency unit. Define WB_LU_BYPASS_EN to let
// an LU result write in its arrival cycle when the port and FIFO are idle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int LU_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(LU_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [REG_AW-1:0] fifo_rd   [LU_DEPTH];
  logic [XLEN-1:0]   fifo_data [LU_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;

  logic            pw, empty, starve, byp, push, pop;
  logic [XLEN-1:0] load_ext, pipe_result;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3  (bus.load_funct3_i),
    .addr_lo (bus.addr_lo_i),
    .word    (bus.load_data_i),
    .ext     (load_ext)
  );

  assign pw             = bus.valid_i & bus.reg_write_i & (bus.rd_i != '0);
  assign empty          = (count == '0);
  assign starve         = !empty && (starve_cnt == SW'(STARVE_MAX));
  assign bus.lu_ready_o = (count < CW'(LU_DEPTH));
  assign bus.dbg_count  = 8'(count);

`ifdef WB_LU_BYPASS_EN
  assign byp = empty & !pw & bus.lu_valid_i & (bus.lu_rd_i != '0);
`else
  assign byp = 1'b0;
`endif

  // rd==0 results are accepted to free the producer but never stored
  assign push = bus.lu_valid_i & bus.lu_ready_o & (bus.lu_rd_i != '0) & !byp;
  assign pop  = !empty & (starve | !pw);

  always_comb begin
    case (result_src_e'(bus.result_src_i))
      RES_ALU:  pipe_result = bus.alu_result_i;
      RES_LOAD: pipe_result = load_ext;
      RES_PC4:  pipe_result = bus.pc_plus4_i;
      default:  pipe_result = bus.imm_ext_i;
    endcase
  end

  always_comb begin
    bus.stall_o     = 1'b0;
    bus.reg_write_o = 1'b0;
    bus.rd_o        = '0;
    bus.result_o    = '0;
    if (starve) begin
      bus.stall_o     = 1'b1;
      bus.reg_write_o = 1'b1;
      bus.rd_o        = fifo_rd[rd_ptr];
      bus.result_o    = fifo_data[rd_ptr];
    end else if (pw) begin
      bus.reg_write_o = 1'b1;
      bus.rd_o        = bus.rd_i;
      bus.result_o    = pipe_result;
    end else if (!empty) begin
      bus.reg_write_o = 1'b1;
      bus.rd_o        = fifo_rd[rd_ptr];
      bus.result_o    = fifo_data[rd_ptr];
    end else if (byp) begin
      bus.reg_write_o = 1'b1;
      bus.rd_o        = bus.lu_rd_i;
      bus.result_o    = bus.lu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= bus.lu_rd_i;
        fifo_data[wr_ptr] <= bus.lu_data_i;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      // Counts only cycles where a waiting head lost the port to the pipeline
      if (pop || empty)
        starve_cnt <= '0;
      else if (pw && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle expected port values go into a
// queue when stimulus is applied and are popped against the DUT at negedge.
module tb_wb_arbiter;

  localparam int W          = 40;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] exp_q[$];

  wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

  wb_arbiter #(.XLEN(32), .REG_AW(5), .LU_DEPTH(4), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int e);
    check(tag, 64'(bus.dbg_count), 64'(e));
  endtask

  // Expected vector: {stall, lu_ready, reg_write, rd, result}
  task automatic cyc(input string tag, input logic e_stall, input logic e_ready,
                     input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_data);
    logic [W-1:0] got;
    exp_q.push_back({e_stall, e_ready, e_we, e_rd, e_data});
    @(negedge clk);
    got = {bus.stall_o, bus.lu_ready_o, bus.reg_write_o, bus.rd_o, bus.result_o};
    check(tag, 64'(got), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_i       = 1'b0;
    bus.reg_write_i   = 1'b0;
    bus.rd_i          = '0;
    bus.result_src_i  = 2'd0;
    bus.alu_result_i  = '0;
    bus.load_data_i   = '0;
    bus.load_funct3_i = 3'b010;
    bus.addr_lo_i     = '0;
    bus.pc_plus4_i    = '0;
    bus.imm_ext_i     = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu);
    bus.valid_i      = 1'b1;
    bus.reg_write_i  = 1'b1;
    bus.rd_i         = rd;
    bus.result_src_i = src;
    bus.alu_result_i = alu;
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.lu_valid_i = v;
    bus.lu_rd_i    = rd;
    bus.lu_data_i  = data;
  endtask

  logic [2:0]  ld_f3  [10] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010,
                               3'b100, 3'b001, 3'b000, 3'b101, 3'b011};
  logic [1:0]  ld_a   [10] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
  logic [31:0] ld_exp [10] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80F1, 32'hFFFF_80F1,
                               32'h80F1_7F02, 32'h0000_0080, 32'h0000_7F02, 32'h0000_0002,
                               32'h0000_7F02, 32'h80F1_7F02};

  initial begin
    idle();
    lu(1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("reset_out", 0, 1, 0, 0, 0);
    check_cnt("reset_cnt", 0);

    // Result source selection
    pipe(5'd1, 2'd0, 32'hDEAD_BEEF);
    cyc("alu", 0, 1, 1, 5'd1, 32'hDEAD_BEEF);
    pipe(5'd2, 2'd2, 32'h0);
    bus.pc_plus4_i = 32'h0000_1004;
    cyc("pc4", 0, 1, 1, 5'd2, 32'h0000_1004);
    pipe(5'd31, 2'd3, 32'h0);
    bus.imm_ext_i = 32'hFFFF_F800;
    cyc("imm", 0, 1, 1, 5'd31, 32'hFFFF_F800);

    // Load extraction
    for (int i = 0; i < 10; i++) begin
      pipe(5'd4, 2'd1, 32'h0);
      bus.load_data_i   = 32'h80F1_7F02;
      bus.load_funct3_i = ld_f3[i];
      bus.addr_lo_i     = ld_a[i];
      cyc("load", 0, 1, 1, 5'd4, ld_exp[i]);
    end

    // x0 suppression
    idle();
    pipe(5'd0, 2'd0, 32'h0000_1234);
    cyc("x0_pipe", 0, 1, 0, 0, 0);
    pipe(5'd4, 2'd0, 32'h0000_1234);
    bus.reg_write_i = 1'b0;
    cyc("no_regwrite", 0, 1, 0, 0, 0);
    idle();
    lu(1'b1, 5'd0, 32'h0000_BEEF);
    cyc("x0_lu", 0, 1, 0, 0, 0);
    lu(1'b0, '0, '0);
    check_cnt("x0_lu_cnt", 0);
    cyc("x0_lu_after", 0, 1, 0, 0, 0);

    // Conflict: pipeline wins, LU result drains on the next free cycle
    pipe(5'd3, 2'd0, 32'h33);
    lu(1'b1, 5'd5, 32'hAA);
    cyc("conflict", 0, 1, 1, 5'd3, 32'h33);
    idle();
    lu(1'b0, '0, '0);
    check_cnt("conflict_cnt", 1);
    cyc("drain", 0, 1, 1, 5'd5, 32'hAA);
    check_cnt("drain_cnt", 0);

    // Fill under continuous pipeline writes, then a held 5th result
    pipe(5'd3, 2'd0, 32'h33);
    for (int i = 0; i < 4; i++) begin
      lu(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      cyc("full_push", 0, 1, 1, 5'd3, 32'h33);
    end
    check_cnt("full_cnt", 4);
    idle();
    lu(1'b1, 5'd14, 32'h105);
    cyc("full_pop0", 0, 0, 1, 5'd10, 32'h100);
    check_cnt("full_held", 3);
    cyc("full_pop1", 0, 1, 1, 5'd11, 32'h101);
    lu(1'b0, '0, '0);
    cyc("full_pop2", 0, 1, 1, 5'd12, 32'h102);
    cyc("full_pop3", 0, 1, 1, 5'd13, 32'h103);
    cyc("full_pop4", 0, 1, 1, 5'd14, 32'h105);
    cyc("full_empty", 0, 1, 0, 0, 0);
    check_cnt("full_end_cnt", 0);

    // Starvation: head waits STARVE_MAX blocked cycles, then forces a stall
    pipe(5'd3, 2'd0, 32'h33);
    lu(1'b1, 5'd20, 32'h77);
    cyc("starve_push", 0, 1, 1, 5'd3, 32'h33);
    lu(1'b0, '0, '0);
    for (int i = 0; i < STARVE_MAX; i++) cyc("starve_wait", 0, 1, 1, 5'd3, 32'h33);
    cyc("starve_hit", 1, 1, 1, 5'd20, 32'h77);
    cyc("starve_resume", 0, 1, 1, 5'd3, 32'h33);
    check_cnt("starve_cnt", 0);

    // Mid-operation reset discards buffered results
    for (int i = 0; i < 3; i++) begin
      lu(1'b1, 5'(21 + i), 32'h200 + 32'(i));
      cyc("rst_fill", 0, 1, 1, 5'd3, 32'h33);
    end
    lu(1'b0, '0, '0);
    idle();
    check_cnt("rst_pre_cnt", 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_cnt("rst_cnt", 0);
    cyc("rst_after", 0, 1, 0, 0, 0);
    cyc("rst_after2", 0, 1, 0, 0, 0);

    // Idle port with an arriving LU result
    lu(1'b1, 5'd7, 32'h55);
`ifdef WB_LU_BYPASS_EN
    cyc("bypass", 0, 1, 1, 5'd7, 32'h55);
    lu(1'b0, '0, '0);
    check_cnt("bypass_cnt", 0);
    cyc("bypass_after", 0, 1, 0, 0, 0);
`else
    cyc("lu_accept", 0, 1, 0, 0, 0);
    lu(1'b0, '0, '0);
    check_cnt("lu_accept_cnt", 1);
    cyc("lu_write", 0, 1, 1, 5'd7, 32'h55);
    check_cnt("lu_write_cnt", 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
